nf_param_output_queues: RTL and testbench

NF_PARAM_OUTPUT_QUEUES -- requirements
Module: nf_param_output_queues

---
 rtl/nf_param_output_queues.sv | 230 +++++++++++++++++++++++
 tb/tb_nf_param_output_queues.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_param_output_queues.sv
// Multicast output queues: one ingress AXI-Stream fanned out to NUM_QUEUES egress streams,
// each backed by a data FIFO and a 4-entry tuser FIFO. Define NF_OQ_DROP_COUNT_EN for drop_count.
module nf_param_output_queues #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 8,
  parameter int DEPTH_BITS         = 7,
  parameter int MAX_PKT_WORDS      = 50,
  parameter int DST_POS            = 24,
  parameter int DROP_MODE          = 1
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]            s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic [NUM_QUEUES-1:0]                     m_axis_tlast,
  output logic [NUM_QUEUES-1:0]                     m_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                     m_axis_tready,
  output logic [NUM_QUEUES-1:0]                     pkt_stored,
  output logic [NUM_QUEUES-1:0]                     pkt_dropped,
  output logic [NUM_QUEUES-1:0]                     pkt_removed
`ifdef NF_OQ_DROP_COUNT_EN
  ,
  output logic [NUM_QUEUES*32-1:0]                  drop_count
`endif
);

  localparam int DW         = C_AXIS_DATA_WIDTH;
  localparam int SW         = C_AXIS_DATA_WIDTH / 8;
  localparam int TW         = C_AXIS_TUSER_WIDTH;
  localparam int NQ         = NUM_QUEUES;
  localparam int FW         = DW + SW + 1;
  localparam int DEPTH      = 1 << DEPTH_BITS;
  localparam int ROOM_LIMIT = DEPTH - MAX_PKT_WORDS;

  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);
  localparam logic [DEPTH_BITS:0]   CNT_ONE = (DEPTH_BITS + 1)'(1);

  typedef enum logic [1:0] {IDLE, WR_PKT, DROP, WAIT_SPACE} state_t;
  typedef enum logic {WAIT_HEADER, WAIT_EOP} trk_t;

  state_t          r_state;
  logic [NQ-1:0]   r_bitmap;
  logic            r_first;
  logic            r_tready;
  logic [NQ-1:0]   r_stored;
  logic [NQ-1:0]   r_dropped;
  logic [NQ-1:0]   r_removed;

  logic [NQ-1:0]   w_bitmap_in;
  logic [NQ-1:0]   w_room;
  logic [NQ-1:0]   w_first_pop;
  logic            w_room_in;
  logic            w_room_lat;
  logic            w_wr_beat;

  assign w_bitmap_in = s_axis_tuser[DST_POS +: NQ];
  // A queue that is not selected never blocks the packet.
  assign w_room_in   = &(w_room | ~w_bitmap_in);
  assign w_room_lat  = &(w_room | ~r_bitmap);
  assign w_wr_beat   = (r_state == WR_PKT) & s_axis_tvalid;

  assign s_axis_tready = r_tready;
  assign pkt_stored    = r_stored;
  assign pkt_dropped   = r_dropped;
  assign pkt_removed   = r_removed;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state   <= IDLE;
      r_bitmap  <= '0;
      r_first   <= 1'b0;
      r_tready  <= 1'b0;
      r_stored  <= '0;
      r_dropped <= '0;
    end else begin
      // NOTE: pulses default low each cycle; a later non-blocking assignment in the same pass wins.
      r_stored  <= '0;
      r_dropped <= '0;
      unique case (r_state)
        IDLE: begin
          if (s_axis_tvalid) begin
            r_bitmap <= w_bitmap_in;
            if (w_bitmap_in == '0) begin
              r_state  <= DROP;
              r_tready <= 1'b1;
            end else if (w_room_in) begin
              r_state  <= WR_PKT;
              r_tready <= 1'b1;
              r_first  <= 1'b1;
              r_stored <= w_bitmap_in;
            end else if (DROP_MODE != 0) begin
              r_state   <= DROP;
              r_tready  <= 1'b1;
              r_dropped <= w_bitmap_in;
            end else begin
              r_state <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (w_room_lat) begin
            r_state  <= WR_PKT;
            r_tready <= 1'b1;
            r_first  <= 1'b1;
            r_stored <= r_bitmap;
          end
        end
        WR_PKT: begin
          if (s_axis_tvalid) begin
            r_first <= 1'b0;
            if (s_axis_tlast) begin
              r_state  <= IDLE;
              r_tready <= 1'b0;
            end
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            r_state  <= IDLE;
            r_tready <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) r_removed <= '0;
    else           r_removed <= w_first_pop;
  end

  for (genvar q = 0; q < NQ; q++) begin : g_queue
    logic [FW-1:0]         r_mem  [DEPTH];
    logic [TW-1:0]         r_umem [4];
    logic [DEPTH_BITS-1:0] r_wptr;
    logic [DEPTH_BITS-1:0] r_rptr;
    logic [DEPTH_BITS:0]   r_count;
    logic [1:0]            r_uwptr;
    logic [1:0]            r_urptr;
    logic [2:0]            r_ucount;
    trk_t                  r_trk;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_upush;
    logic                  w_upop;
    logic [FW-1:0]         w_head;

    // Count MSB set means exactly DEPTH words held.
    assign w_push         = w_wr_beat & r_bitmap[q] & ~r_count[DEPTH_BITS];
    assign w_pop          = m_axis_tready[q] & (r_count != '0);
    assign w_upush        = w_wr_beat & r_bitmap[q] & r_first & ~r_ucount[2];
    assign w_first_pop[q] = w_pop & (r_trk == WAIT_HEADER);
    assign w_upop         = w_first_pop[q] & (r_ucount != '0);
    assign w_room[q]      = (int'(r_count) <= ROOM_LIMIT) && (r_ucount <= 3'd2);
    assign w_head         = r_mem[r_rptr];

    // NOTE: storage arrays have no reset; pointers and counts alone define what is valid.
    always_ff @(posedge axi_aclk) begin
      if (w_push)  r_mem[r_wptr]   <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
      if (w_upush) r_umem[r_uwptr] <= s_axis_tuser;
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_count  <= '0;
        r_uwptr  <= '0;
        r_urptr  <= '0;
        r_ucount <= '0;
        r_trk    <= WAIT_HEADER;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_ONE;
        if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
        if (w_upush) r_uwptr <= r_uwptr + 2'd1;
        if (w_upop)  r_urptr <= r_urptr + 2'd1;
        case ({w_upush, w_upop})
          2'b10:   r_ucount <= r_ucount + 3'd1;
          2'b01:   r_ucount <= r_ucount - 3'd1;
          default: r_ucount <= r_ucount;
        endcase
        // Tracker re-arms for the next header once the word carrying tlast leaves.
        if (w_pop) r_trk <= w_head[FW-1] ? WAIT_HEADER : WAIT_EOP;
      end
    end

    assign m_axis_tdata[q*DW +: DW] = w_head[DW-1:0];
    assign m_axis_tstrb[q*SW +: SW] = w_head[DW +: SW];
    assign m_axis_tlast[q]          = w_head[FW-1];
    assign m_axis_tvalid[q]         = (r_count != '0);
    assign m_axis_tuser[q*TW +: TW] = r_umem[r_urptr];
  end

`ifdef NF_OQ_DROP_COUNT_EN
  logic [31:0] r_drop_cnt [NQ];

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < NQ; i++) r_drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (r_dropped[i] && (r_drop_cnt[i] != 32'hFFFF_FFFF))
          r_drop_cnt[i] <= r_drop_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar q = 0; q < NQ; q++) begin : g_drop_cnt
    assign drop_count[q*32 +: 32] = r_drop_cnt[q];
  end
`endif

endmodule

// File: tb/tb_nf_param_output_queues.sv
// Bench for nf_param_output_queues: one drop-mode and one backpressure-mode instance share the
// ingress stimulus; a queue-based scoreboard predicts every egress word, tuser and event pulse.
module tb_nf_param_output_queues;

  localparam int NQ    = 8;
  localparam int DW    = 64;
  localparam int SW    = 8;
  localparam int TW    = 128;
  localparam int DEPTH = 16;
  localparam int MAXW  = 4;
  localparam int DPOS  = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic [TW-1:0] tuser;
  logic          tvalid;
  logic          tlast;
  logic [NQ-1:0] m_tready;
  logic          sel;

  wire            rdy_a, rdy_b;
  wire [NQ*DW-1:0] md_a, md_b;
  wire [NQ*SW-1:0] ms_a, ms_b;
  wire [NQ*TW-1:0] mu_a, mu_b;
  wire [NQ-1:0]    ml_a, ml_b, mv_a, mv_b;
  wire [NQ-1:0]    st_a, st_b, dr_a, dr_b, rm_a, rm_b;
`ifdef NF_OQ_DROP_COUNT_EN
  wire [NQ*32-1:0] dc_a, dc_b;
`endif

  always #5 clk = ~clk;

  nf_param_output_queues #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW), .NUM_QUEUES(NQ), .DEPTH_BITS(4),
    .MAX_PKT_WORDS(MAXW), .DST_POS(DPOS), .DROP_MODE(1)
  ) u_dut_drop (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid & ~sel), .s_axis_tlast(tlast), .s_axis_tready(rdy_a),
    .m_axis_tdata(md_a), .m_axis_tstrb(ms_a), .m_axis_tuser(mu_a), .m_axis_tlast(ml_a),
    .m_axis_tvalid(mv_a), .m_axis_tready(m_tready),
    .pkt_stored(st_a), .pkt_dropped(dr_a), .pkt_removed(rm_a)
`ifdef NF_OQ_DROP_COUNT_EN
    , .drop_count(dc_a)
`endif
  );

  nf_param_output_queues #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW), .NUM_QUEUES(NQ), .DEPTH_BITS(4),
    .MAX_PKT_WORDS(MAXW), .DST_POS(DPOS), .DROP_MODE(0)
  ) u_dut_bp (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid & sel), .s_axis_tlast(tlast), .s_axis_tready(rdy_b),
    .m_axis_tdata(md_b), .m_axis_tstrb(ms_b), .m_axis_tuser(mu_b), .m_axis_tlast(ml_b),
    .m_axis_tvalid(mv_b), .m_axis_tready(m_tready),
    .pkt_stored(st_b), .pkt_dropped(dr_b), .pkt_removed(rm_b)
`ifdef NF_OQ_DROP_COUNT_EN
    , .drop_count(dc_b)
`endif
  );

  wire             rdy_m = sel ? rdy_b : rdy_a;
  wire [NQ*DW-1:0] md_m  = sel ? md_b  : md_a;
  wire [NQ*SW-1:0] ms_m  = sel ? ms_b  : ms_a;
  wire [NQ*TW-1:0] mu_m  = sel ? mu_b  : mu_a;
  wire [NQ-1:0]    ml_m  = sel ? ml_b  : ml_a;
  wire [NQ-1:0]    mv_m  = sel ? mv_b  : mv_a;
  wire [NQ-1:0]    st_m  = sel ? st_b  : st_a;
  wire [NQ-1:0]    dr_m  = sel ? dr_b  : dr_a;
  wire [NQ-1:0]    rm_m  = sel ? rm_b  : rm_a;

  // Reference model: expected egress words {tlast,tstrb,tdata} and tuser values per queue.
  logic [DW+SW:0] exp_q [NQ][$];
  logic [TW-1:0]  exp_u [NQ][$];
  logic           in_pkt [NQ];
  int e_st [NQ], e_dr [NQ], e_rm [NQ], e_dc [NQ];
  int n_st [NQ], n_dr [NQ], n_rm [NQ];
  int n_tests = 0;
  int n_fail  = 0;

  logic [DW+SW:0] mon_word;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_room(input int q);
    return ((DEPTH - exp_q[q].size()) >= MAXW) && (exp_u[q].size() <= 2);
  endfunction

  task automatic reset_model();
    for (int q = 0; q < NQ; q++) begin
      exp_q[q].delete();
      exp_u[q].delete();
      in_pkt[q] = 1'b0;
      e_dc[q]   = 0;
    end
  endtask

  // Egress monitor: sampled on the falling edge, a valid&ready word pops at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int q = 0; q < NQ; q++) begin
        n_st[q] += int'(st_m[q]);
        n_dr[q] += int'(dr_m[q]);
        n_rm[q] += int'(rm_m[q]);
        if (mv_m[q] && m_tready[q]) begin
          mon_word = {ml_m[q], ms_m[q*SW +: SW], md_m[q*DW +: DW]};
          chk("pop_expected", exp_q[q].size() != 0, 1'b1);
          if (exp_q[q].size() != 0) chk("egress_word", mon_word, exp_q[q].pop_front());
          if (!in_pkt[q]) begin
            chk("tuser_expected", exp_u[q].size() != 0, 1'b1);
            if (exp_u[q].size() != 0) chk("egress_tuser", mu_m[q*TW +: TW], exp_u[q].pop_front());
          end
          in_pkt[q] = ~ml_m[q];
        end
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l,
                            input logic [TW-1:0] u);
    int   cyc;
    logic acc;
    tdata = d; tstrb = s; tlast = l; tuser = u; tvalid = 1'b1;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 300) begin
      @(negedge clk);
      acc = rdy_m;
      cyc++;
    end
    chk("beat_accept", acc, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [NQ-1:0] bm, input int nb);
    logic          store;
    logic [TW-1:0] tu;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    tu = {$urandom, $urandom, $urandom, $urandom};
    tu[DPOS +: NQ] = bm;
    store = (bm != '0);
    if (store && !sel)
      for (int q = 0; q < NQ; q++) if (bm[q] && !model_room(q)) store = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      if (bm[q] && store) begin
        exp_u[q].push_back(tu);
        e_st[q]++;
        e_rm[q]++;
      end else if (bm[q] && !sel) begin
        e_dr[q]++;
        e_dc[q]++;
      end
    end
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      s = SW'($urandom);
      drive_beat(d, s, b == nb - 1, tu);
      if (store)
        for (int q = 0; q < NQ; q++) if (bm[q]) exp_q[q].push_back({b == nb - 1, s, d});
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic drain();
    m_tready = '1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  logic [TW-1:0] tu_r;

  initial begin
    rst = 1'b1; sel = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tstrb = '0; tuser = '0; m_tready = '0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tready", rdy_a, 1'b0);
    chk("reset_tvalid_a", mv_a, 8'h00);
    chk("reset_tvalid_b", mv_b, 8'h00);
    chk("reset_pulses", {st_a, dr_a, rm_a}, 24'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-queue 3-beat packet held back, then released.
    send_pkt(8'h04, 3);
    @(negedge clk);
    chk("q2_only_valid", mv_m, 8'h04);
    chk("q2_stored_once", n_st[2], 1);
    drain();
    chk("q2_removed_once", n_rm[2], 1);
    chk("q2_drained", exp_q[2].size(), 0);

    // Multicast to queues 0 and 7.
    m_tready = '0;
    send_pkt(8'h81, 3);
    @(negedge clk);
    chk("mcast_valid", mv_m, 8'h81);
    drain();
    chk("mcast_removed_q0", n_rm[0], 1);
    chk("mcast_removed_q7", n_rm[7], 1);

    // Reset during beat 2 of a 4-beat packet.
    m_tready = '0;
    tu_r = {$urandom, $urandom, $urandom, $urandom};
    tu_r[DPOS +: NQ] = 8'h08;
    e_st[3]++;
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, tu_r);
    tdata = {$urandom, $urandom};
    @(negedge clk);
    chk("pre_reset_valid", mv_m, 8'h08);
    rst = 1'b1;
    #1;
    tvalid = 1'b0;
    reset_model();
    chk("mid_reset_valid", mv_m, 8'h00);
    @(negedge clk);
    chk("post_reset_valid", mv_m, 8'h00);
    chk("post_reset_tready", rdy_m, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    tu_r[DPOS +: NQ] = 8'h08;
    tuser = tu_r;
    tvalid = 1'b1;
    @(negedge clk);
    chk("first_accept_latency", rdy_m, 1'b0);
    send_pkt(8'h08, 4);
    drain();
    chk("after_reset_removed", n_rm[3], 1);

    // Three drops to queue 0 once it is out of room.
    m_tready = 8'hFE;
    for (int i = 0; i < 6; i++) send_pkt(8'h01, 2);
    chk("q0_drops", n_dr[0], 3);
`ifdef NF_OQ_DROP_COUNT_EN
    for (int q = 0; q < NQ; q++) chk("drop_count_slice", dc_a[q*32 +: 32], 32'(e_dc[q]));
`endif
    drain();

    // Drop mode: fill queue 1, next packet is consumed and dropped.
    m_tready = 8'hFD;
    for (int i = 0; i < 3; i++) send_pkt(8'h02, 2);
    @(negedge clk);
    chk("q1_full_valid", mv_m, 8'h02);
    send_pkt(8'h02, 3);
    chk("q1_dropped", n_dr[1], 1);
    chk("q1_depth_kept", exp_q[1].size(), 6);
    drain();
    chk("q1_drained", exp_q[1].size(), 0);

    // Backpressure mode: ingress stalls until queue 1 frees space.
    sel = 1'b1;
    m_tready = 8'hFD;
    for (int i = 0; i < 3; i++) send_pkt(8'h02, 2);
    fork
      send_pkt(8'h02, 3);
      begin
        repeat (8) begin
          @(negedge clk);
          chk("bp_tready_held", rdy_m, 1'b0);
        end
        m_tready[1] = 1'b1;
      end
    join
    chk("bp_no_drop", n_dr[1], e_dr[1]);
    drain();

    // Randomized traffic on both instances with free-running egress.
    for (int pass = 0; pass < 2; pass++) begin
      sel = pass[0];
      m_tready = '1;
      for (int i = 0; i < 40; i++) begin
        send_pkt(NQ'($urandom_range(0, 255)), $urandom_range(1, MAXW));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      drain();
    end

    for (int q = 0; q < NQ; q++) begin
      chk("final_stored", n_st[q], e_st[q]);
      chk("final_dropped", n_dr[q], e_dr[q]);
      chk("final_removed", n_rm[q], e_rm[q]);
      chk("final_empty", exp_q[q].size(), 0);
`ifdef NF_OQ_DROP_COUNT_EN
      chk("final_drop_count", dc_a[q*32 +: 32], 32'(e_dc[q]));
      chk("final_drop_count_bp", dc_b[q*32 +: 32], 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
